// File: rtl/shift_seq_ctrl.sv
// -----------------------------------------------------------------------------
// shift_seq_ctrl
//
// Multi-cycle sequencer for the ALU32 shift/truncate path. One request is
// accepted per start pulse; the latched operand is then shifted by one bit
// per clock for N clocks, and the result is returned in cout1 together with
// a one-cycle done strobe. This is the small serial alternative to a
// combinational barrel shifter.
//
// Ports
//   clk    : system clock, all state changes on the rising edge
//   rst_n  : synchronous active-low reset
//   start  : request strobe, only looked at while not busy
//   op     : 00 SLL, 01 SRL, 10 SRA, 11 ROR
//   In1    : operand to shift
//   In2    : amount source, In2[SHW-1:0] = amount, In2[WIDTH-1] = complement
//   busy   : high while shifting (exactly N cycles per request)
//   done   : result valid strobe
//   cout1  : result register, held until the next completion
// -----------------------------------------------------------------------------
module shift_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] cout1
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    localparam logic [SHW-1:0] CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};
    localparam logic [SHW-1:0] CNT_ZERO = {SHW{1'b0}};

    state_t           r_state;
    logic [WIDTH-1:0] r_data;
    logic [SHW-1:0]   r_count;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_cout1;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_shifted;
    logic [SHW-1:0]   w_amount;
    logic             w_accept;

    // Effective amount. With the complement flag set the amount is
    // (2^SHW - amt) mod 2^SHW, which is simply the two's complement
    // negation in SHW bits, so a zero amount stays zero.
    function automatic logic [SHW-1:0] f_eff_amount(input logic [WIDTH-1:0] src);
        logic [SHW-1:0] amt;
        amt = src[SHW-1:0];
        if (src[WIDTH-1]) begin
            f_eff_amount = CNT_ZERO - amt;
        end else begin
            f_eff_amount = amt;
        end
    endfunction

    // One-bit shift step for the selected operation.
    function automatic logic [WIDTH-1:0] f_shift_one(input logic [WIDTH-1:0] d,
                                                     input logic [1:0]       sel);
        case (sel)
            OP_SLL:  f_shift_one = {d[WIDTH-2:0], 1'b0};
            OP_SRL:  f_shift_one = {1'b0, d[WIDTH-1:1]};
            OP_SRA:  f_shift_one = {d[WIDTH-1], d[WIDTH-1:1]};
            OP_ROR:  f_shift_one = {d[0], d[WIDTH-1:1]};
            default: f_shift_one = d;
        endcase
    endfunction

    // Next-step data value and the amount decoded from the live inputs.
    always_comb begin
        w_shifted = f_shift_one(r_data, r_op);
        w_amount  = f_eff_amount(In2);
        // A new request can be taken in IDLE and also in DONE, which lets
        // back-to-back requests run without an IDLE bubble.
        if ((r_state == ST_IDLE) || (r_state == ST_DONE)) begin
            w_accept = start;
        end else begin
            w_accept = 1'b0;
        end
    end

    // Sequencer state, operand/count registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_data  <= {WIDTH{1'b0}};
            r_count <= CNT_ZERO;
            r_op    <= 2'b00;
            r_cout1 <= {WIDTH{1'b0}};
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        r_data  <= In1;
                        r_count <= w_amount;
                        r_op    <= op;
                        if (w_amount == CNT_ZERO) begin
                            // Zero amount completes at the accepting edge.
                            r_cout1 <= In1;
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_SHIFT;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    r_data  <= w_shifted;
                    r_count <= r_count - CNT_ONE;
                    if (r_count == CNT_ONE) begin
                        // Last step: publish the shifted value directly.
                        r_cout1 <= w_shifted;
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= ST_SHIFT;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign cout1 = r_cout1;

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
- Multi-cycle sequencer for the 32-bit ALU shift/truncate path.
- Accepts one shift request per start pulse and applies a one-bit shift per clock, N cycles in total, to a latched operand.
- Returns the result with a one-cycle done strobe.
- Sits beside the ALU32 datapath as the area-cheap alternative to a combinational barrel shifter.

Parameters:
- WIDTH, 32, data width of In1/In2/cout1.
- SHW, 5, width of the shift-amount field In2[SHW-1:0].

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request strobe; sampled only when not busy.
- op  input  2  shift operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- In1  input  WIDTH  operand to shift.
- In2  input  WIDTH  amount source: In2[SHW-1:0] = amount, In2[WIDTH-1] = complement flag.
- busy  output  1  high while in SHIFT state.
- done  output  1  one-cycle strobe, result valid.
- cout1  output  WIDTH  result register; holds the last result until the next completion.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; busy=0, done=0, cout1=0; internal data, count and op registers cleared.
  - Reset mid-SHIFT aborts the operation: no done is produced and cout1 is cleared.
- Effective amount N, computed at the accepting edge:
  - In2[31]=0: N = In2[4:0].
  - In2[31]=1: N = (32 - In2[4:0]) mod 32.
  - So In2=0x8000_0000 gives N=0.
- States are IDLE, SHIFT and DONE. busy = (state==SHIFT); done = (state==DONE).
- IDLE or DONE with start=1:
  - Latch In1 into data, N into count, op into op_r.
  - N=0: next state is DONE and cout1 <= In1.
  - N>0: next state is SHIFT.
- IDLE with start=0: stay. DONE with start=0: go to IDLE.
- SHIFT, every edge:
  - data is shifted by one bit per op_r:
    - SLL: data<<1, zero fill.
    - SRL: data>>1, zero fill.
    - SRA: data>>1, fill with data[31].
    - ROR: {data[0], data[31:1]}.
  - count decrements by 1.
  - When count==1: cout1 <= shifted value and next state is DONE.
- Latency: for a start sampled at edge E0, done and the new cout1 are visible after edge E0+N. busy is high for exactly N cycles.
- Back-to-back requests: start in the DONE cycle is accepted, giving no IDLE bubble. done then lasts one cycle, or longer if the new N=0, in which case done stays high on consecutive completions.
- start while busy=1 is ignored. In1, In2 and op may change freely after acceptance without affecting the operation in flight.
- cout1 changes only on entry to DONE or on reset.

Test Plan:
- Reset: hold rst_n=0 for 2 edges mid-operation (after starting SLL with N=10) -> busy=0, done=0, cout1=0x0000_0000; no done pulse follows.
- SLL: In1=0x0000_0001, In2=0x0000_0004, op=00, start 1 cycle -> busy high 4 cycles; done after E0+4; cout1=0x0000_0010.
- SRA: In1=0x8000_0000, In2=0x0000_001F, op=10 -> done after E0+31; cout1=0xFFFF_FFFF. Repeat with op=01 -> cout1=0x0000_0001.
- Complement flag with ROR: In1=0x1234_5678, In2=0x8000_0008 (N=24), op=11 -> busy 24 cycles; cout1=0x3456_7812.
- Zero amount: In1=0xDEAD_BEEF, In2=0x8000_0000, op=01 -> busy never high; done after E0+0; cout1=0xDEAD_BEEF.
- Handshake:
  - Pulse start again during SHIFT with different operands -> ignored; result equals the first request.
  - Assert start in the DONE cycle with SLL In1=0x1, In2=0x2 -> accepted immediately; second done after 2 further edges; cout1=0x0000_0004.
